// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter, MSB first; first bit one cycle after accept. Optional PISO_PARITY_EN appends an even-parity bit.
// Latency: bit k of an accepted word appears k+1 cycles after the handshake edge.
// Backpressure: load_ready is high in IDLE and in the word's final serial cycle only.
module piso_shift_tx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] din,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  logic par_q, par_d;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_bit;
  logic             accept;

  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST);

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
`ifdef PISO_PARITY_EN
    par_d      = par_q;
`endif
    load_ready = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    done       = 1'b0;

    case (state_q)
      IDLE: load_ready = 1'b1;
      SHIFT: begin
        sout       = shreg_q[WIDTH-1];
        sout_valid = 1'b1;
`ifndef PISO_PARITY_EN
        done       = last_bit;
        load_ready = last_bit;
`endif
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        sout       = par_q;
        sout_valid = 1'b1;
        done       = 1'b1;
        load_ready = 1'b1;
      end
`endif
      default: ;
    endcase

    accept = load_valid && load_ready;

    if (accept) begin
      state_d = SHIFT;
      shreg_d = din;
      cnt_d   = '0;
`ifdef PISO_PARITY_EN
      par_d   = ^din;
`endif
    end else if (state_q == SHIFT) begin
      shreg_d = shreg_q << 1;
      if (last_bit) begin
`ifdef PISO_PARITY_EN
        state_d = PARITY;
`else
        state_d = IDLE;
`endif
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      // Parity cycle with no new word waiting.
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed bench for piso_shift_tx: a WIDTH=4 and a WIDTH=1 instance, plus a SIPO receiver model.
// Observed outputs are packed as {sout, sout_valid, done, load_ready} per cycle.
module tb_piso_shift_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lv4 = 1'b0;
  logic [3:0] din4 = 4'b0;
  logic       rdy4, sout4, vld4, done4;
  logic       lv1 = 1'b0;
  logic [0:0] din1 = 1'b0;
  logic       rdy1, sout1, vld1, done1;
  logic [3:0] obs4, obs1, sipo_q;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  piso_shift_tx #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .load_valid(lv4), .din(din4),
    .load_ready(rdy4), .sout(sout4), .sout_valid(vld4), .done(done4)
  );

  piso_shift_tx #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .load_valid(lv1), .din(din1),
    .load_ready(rdy1), .sout(sout1), .sout_valid(vld1), .done(done1)
  );

  assign obs4 = {sout4, vld4, done4, rdy4};
  assign obs1 = {sout1, vld1, done1, rdy1};

  // Receiving shift register driven by sout on the same clock.
  always @(posedge clk) begin
    if (rst) sipo_q <= 4'b0;
    else if (vld4) sipo_q <= {sipo_q[2:0], sout4};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; lv4 = 1'b1; din4 = 4'b1111; lv1 = 1'b1; din1 = 1'b1;
    step();
    step();
    checks++;
    if (obs4 !== 4'b0001) begin errors++; $display("FAIL reset_w4 obs=%b exp=0001", obs4); end
    checks++;
    if (obs1 !== 4'b0001) begin errors++; $display("FAIL reset_w1 obs=%b exp=0001", obs1); end
    rst = 1'b0; lv4 = 1'b0; lv1 = 1'b0;
    step();
    checks++;
    if (obs4 !== 4'b0001) begin errors++; $display("FAIL idle_after_reset obs=%b exp=0001", obs4); end
  endtask

  task automatic test_basic();
    logic       lv[$];
    logic [3:0] dn[$];
    logic [3:0] ex[$];
`ifdef PISO_PARITY_EN
    lv = '{1, 0, 0, 0, 0, 0, 0};
    dn = '{4'b1011, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
    ex = '{4'b0001, 4'b1100, 4'b0100, 4'b1100, 4'b1100, 4'b1111, 4'b0001};
`else
    lv = '{1, 0, 0, 0, 0, 0};
    dn = '{4'b1011, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
    ex = '{4'b0001, 4'b1100, 4'b0100, 4'b1100, 4'b1111, 4'b0001};
`endif
    for (int i = 0; i < ex.size(); i++) begin
      lv4 = lv[i]; din4 = dn[i];
      checks++;
      if (obs4 !== ex[i]) begin errors++; $display("FAIL basic cyc%0d obs=%b exp=%b", i, obs4, ex[i]); end
      step();
    end
    checks++;
    if (sipo_q !== 4'b1011) begin errors++; $display("FAIL basic_sipo q=%b exp=1011", sipo_q); end
  endtask

  task automatic test_back_to_back();
    logic       lv[$];
    logic [3:0] dn[$];
    logic [3:0] ex[$];
`ifdef PISO_PARITY_EN
    lv = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    dn = '{4'b1100, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011,
           4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011};
    ex = '{4'b0001, 4'b1100, 4'b1100, 4'b0100, 4'b0100, 4'b0111,
           4'b0100, 4'b0100, 4'b1100, 4'b1100, 4'b0111, 4'b0001};
`else
    lv = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    dn = '{4'b1100, 4'b0011, 4'b0011, 4'b0011, 4'b0011,
           4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011};
    ex = '{4'b0001, 4'b1100, 4'b1100, 4'b0100, 4'b0111,
           4'b0100, 4'b0100, 4'b1100, 4'b1111, 4'b0001};
`endif
    for (int i = 0; i < ex.size(); i++) begin
      lv4 = lv[i]; din4 = dn[i];
      checks++;
      if (obs4 !== ex[i]) begin errors++; $display("FAIL b2b cyc%0d obs=%b exp=%b", i, obs4, ex[i]); end
      step();
    end
  endtask

  task automatic test_busy_ignore();
    logic       lv[$];
    logic [3:0] dn[$];
    logic [3:0] ex[$];
`ifdef PISO_PARITY_EN
    lv = '{1, 1, 1, 0, 0, 0, 0};
    dn = '{4'b1001, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0110};
    ex = '{4'b0001, 4'b1100, 4'b0100, 4'b0100, 4'b1100, 4'b0111, 4'b0001};
`else
    lv = '{1, 1, 1, 0, 0, 0};
    dn = '{4'b1001, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0110};
    ex = '{4'b0001, 4'b1100, 4'b0100, 4'b0100, 4'b1111, 4'b0001};
`endif
    for (int i = 0; i < ex.size(); i++) begin
      lv4 = lv[i]; din4 = dn[i];
      checks++;
      if (obs4 !== ex[i]) begin errors++; $display("FAIL busy cyc%0d obs=%b exp=%b", i, obs4, ex[i]); end
      step();
    end
`ifndef PISO_PARITY_EN
    checks++;
    if (sipo_q !== 4'b1001) begin errors++; $display("FAIL busy_sipo q=%b exp=1001", sipo_q); end
`endif
  endtask

  task automatic test_reset_midword();
    logic       rs[$];
    logic       lv[$];
    logic [3:0] dn[$];
    logic [3:0] ex[$];
`ifdef PISO_PARITY_EN
    rs = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    lv = '{1, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    dn = '{4'b1111, 4'b0, 4'b0, 4'b0101, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
    ex = '{4'b0001, 4'b1100, 4'b1100, 4'b0001, 4'b0100,
           4'b1100, 4'b0100, 4'b1100, 4'b0111, 4'b0001};
`else
    rs = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
    lv = '{1, 0, 1, 1, 0, 0, 0, 0, 0};
    dn = '{4'b1111, 4'b0, 4'b0, 4'b0101, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
    ex = '{4'b0001, 4'b1100, 4'b1100, 4'b0001, 4'b0100,
           4'b1100, 4'b0100, 4'b1111, 4'b0001};
`endif
    for (int i = 0; i < ex.size(); i++) begin
      rst = rs[i]; lv4 = lv[i]; din4 = dn[i];
      checks++;
      if (obs4 !== ex[i]) begin errors++; $display("FAIL rst_mid cyc%0d obs=%b exp=%b", i, obs4, ex[i]); end
      step();
    end
    rst = 1'b0;
`ifndef PISO_PARITY_EN
    checks++;
    if (sipo_q !== 4'b0101) begin errors++; $display("FAIL rst_mid_sipo q=%b exp=0101", sipo_q); end
`endif
  endtask

  task automatic test_width1();
    logic       lv[$];
    logic [0:0] dn[$];
    logic [3:0] ex[$];
`ifdef PISO_PARITY_EN
    lv = '{1, 1, 1, 1, 1, 1, 0, 0};
    dn = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ex = '{4'b0001, 4'b1100, 4'b1111, 4'b0100, 4'b0111, 4'b1100, 4'b1111, 4'b0001};
`else
    lv = '{1, 1, 1, 0, 0};
    dn = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    ex = '{4'b0001, 4'b1111, 4'b0111, 4'b1111, 4'b0001};
`endif
    for (int i = 0; i < ex.size(); i++) begin
      lv1 = lv[i]; din1 = dn[i];
      checks++;
      if (obs1 !== ex[i]) begin errors++; $display("FAIL width1 cyc%0d obs=%b exp=%b", i, obs1, ex[i]); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_busy_ignore();
    test_reset_midword();
    test_width1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
